fir_coef_bank_ctrl: RTL and testbench
=====================================

FIR_COEF_BANK_CTRL -- requirements
Module: fir_coef_bank_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port PushCoef, input, 1, coefficient write strobe.
REQ-004 SHALL have port CoefAddr, input, 5, unique-tap address; legal range 0..14.
REQ-005 SHALL have port CoefI, input, 27, signed 3.24 in-phase coefficient.
REQ-006 SHALL have port CoefQ, input, 27, signed 3.24 quadrature coefficient.
REQ-007 SHALL have port SampleStart, input, 1, one-cycle pulse when the datapath pulls a sample and begins a new output.
REQ-008 SHALL have port GroupSel, input, 2, tap group being multiplied; legal range 0..2.
REQ-009 SHALL have port CoefGrpI, output, 135, five 27-bit I coefficients of the selected group; tap 5*g+k at bits [27k+26:27k].
REQ-010 SHALL have port CoefGrpQ, output, 135, same packing for Q.
REQ-011 SHALL have port CoefValid, output, 1, high once the active bank holds a complete coefficient set.
REQ-012 SHALL have port SwapPending, output, 1, high while the shadow bank differs from the active bank.
REQ-013 SHALL have port CoefErr, output, 1, one-cycle pulse on an illegal write address.

Function
REQ-014 SHALL hold two 15-entry banks, shadow and active, each entry {I,Q}.
REQ-015 SHALL write CoefI/CoefQ into shadow[CoefAddr] on a cycle with PushCoef=1 and CoefAddr<15; active bank is never written directly.
REQ-016 SHALL ignore writes with CoefAddr>=15, raising CoefErr for the following cycle only; no state changes.
REQ-017 SHALL keep a 15-bit loaded mask, setting bit CoefAddr on every legal write; mask clears only on reset.
REQ-018 SHALL implement FSM EMPTY -> (mask all-ones) -> DIRTY -> (swap) -> CLEAN -> (legal write) -> DIRTY.
REQ-019 SHALL in EMPTY ignore SampleStart; CoefValid=0; shadow writes still accepted.
REQ-020 SHALL perform a swap (active <= shadow, whole bank, one edge) when state is DIRTY, SampleStart=1 and PushCoef=0 in the same cycle.
REQ-021 SHALL defer the swap to the next qualifying SampleStart if PushCoef=1 coincides with SampleStart; the coinciding write lands in shadow.
REQ-022 SHALL never swap except on SampleStart, so one output is computed entirely with one coefficient set.
REQ-023 SHALL set CoefValid=1 on the edge of the first swap and keep it 1 until reset.
REQ-024 SHALL drive SwapPending=1 exactly in state DIRTY.
REQ-025 SHALL register CoefGrpI/Q: value after edge n reflects GroupSel and active bank as updated at edge n (latency 1 cycle; a swap and a GroupSel sample on the same edge yield new-bank data).
REQ-026 SHALL drive CoefGrpI/Q to zero when GroupSel=3 or CoefValid=0.
REQ-027 SHALL keep shadow contents after a swap, so partial updates re-use unchanged taps.

Reset
REQ-028 SHALL on Reset=0 at a clock edge clear both banks, the mask, CoefGrpI/Q, CoefValid, SwapPending, CoefErr and enter EMPTY, overriding any coincident write or swap.
REQ-029 SHALL behave identically for reset asserted mid-load or mid-swap; no partial state survives.

Structure
REQ-030 SHALL take Coef typedef {I,Q}, NUM_UNIQUE_TAPS=15, GROUP_SIZE=5, NUM_GROUPS=3 from shared package fir_pkg.
REQ-031 SHALL place the 15-entry bank in sub-module fir_coef_bank, instantiated as shadow and active.

Verification
REQ-032 SHALL cover: write addr 0..14 with I=addr+1, Q=-(addr+1), pulse SampleStart -> CoefValid=1, GroupSel=1 gives I taps 6..10 one cycle later.
REQ-033 SHALL cover: full load, 14 addrs only then SampleStart -> no swap, CoefValid=0, outputs zero.
REQ-034 SHALL cover: after valid, rewrite addr 7 I=0x100000 with PushCoef=1 during SampleStart -> SwapPending stays 1, old tap used; next SampleStart -> swap, SwapPending=0.
REQ-035 SHALL cover: write CoefAddr=20 -> CoefErr pulses one cycle, mask and banks unchanged.
REQ-036 SHALL cover: Reset=0 one cycle while DIRTY -> all outputs 0 next cycle, state EMPTY, SampleStart ignored.
REQ-037 SHALL cover: GroupSel=3 with valid bank -> CoefGrpI/Q=0 one cycle later.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared coefficient types and tap geometry for the FIR coefficient bank.
package fir_pkg;
    localparam int COEF_W          = 27;
    localparam int NUM_UNIQUE_TAPS = 15;
    localparam int GROUP_SIZE      = 5;
    localparam int NUM_GROUPS      = 3;
    localparam int ADDR_W          = 5;
    localparam int TAP_IDX_W       = 4;
    localparam int GRP_W           = GROUP_SIZE * COEF_W;

    typedef struct packed {
        logic signed [COEF_W-1:0] i;
        logic signed [COEF_W-1:0] q;
    } coef_t;

    typedef coef_t [NUM_UNIQUE_TAPS-1:0] coef_bank_t;

    function automatic logic tap_addr_legal(input logic [ADDR_W-1:0] addr);
        return int'(addr) < NUM_UNIQUE_TAPS;
    endfunction
endpackage

// File: rtl/fir_coef_bank.sv
// One 15-entry {I,Q} coefficient bank: single-entry write port plus whole-bank load.
module fir_coef_bank
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [TAP_IDX_W-1:0] wr_addr_i,
    input  coef_t                wr_data_i,
    input  logic                 load_en_i,
    input  coef_bank_t           load_data_i,
    output coef_bank_t           data_o
);
    coef_bank_t mem_q;
    coef_bank_t mem_d;

    // NOTE: start every always_comb from a full default so no path leaves a variable unassigned (no latch).
    always_comb begin
        mem_d = mem_q;
        if (load_en_i) begin
            mem_d = load_data_i;
        end else if (wr_en_i) begin
            mem_d[wr_addr_i] = wr_data_i;
        end
    end

    // NOTE: the banks are flop-based and must read as all-zero after reset, so the storage itself is reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign data_o = mem_q;
endmodule

// File: rtl/fir_coef_bank_ctrl.sv
// Double-buffered FIR coefficient store: writes land in the shadow bank, and the
// active bank is replaced atomically only at a sample boundary.
module fir_coef_bank_ctrl
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    input  logic              PushCoef,
    input  logic [ADDR_W-1:0] CoefAddr,
    input  logic [COEF_W-1:0] CoefI,
    input  logic [COEF_W-1:0] CoefQ,
    input  logic              SampleStart,
    input  logic [1:0]        GroupSel,
    output logic [GRP_W-1:0]  CoefGrpI,
    output logic [GRP_W-1:0]  CoefGrpQ,
    output logic              CoefValid,
    output logic              SwapPending,
    output logic              CoefErr
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_DIRTY = 2'd1;
    localparam logic [1:0] ST_CLEAN = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [NUM_UNIQUE_TAPS-1:0] mask_q, mask_d;
    logic                       valid_q, valid_d;
    logic                       err_q, err_d;
    logic [GRP_W-1:0]           grp_i_q, grp_i_d;
    logic [GRP_W-1:0]           grp_q_q, grp_q_d;
    logic                       addr_legal;
    logic                       wr_ok;
    logic                       swap;
    logic [TAP_IDX_W-1:0]       tap_idx;
    logic [TAP_IDX_W-1:0]       grp_tap;
    coef_t                      wr_coef;
    coef_bank_t                 shadow_bank;
    coef_bank_t                 active_bank;
    coef_bank_t                 active_next;

    assign addr_legal = tap_addr_legal(CoefAddr);
    assign wr_ok      = PushCoef && addr_legal;
    assign tap_idx    = CoefAddr[TAP_IDX_W-1:0];
    assign wr_coef    = '{i: CoefI, q: CoefQ};
    // A write in the same cycle as SampleStart wins; the swap waits for the next sample.
    assign swap       = (state_q == ST_DIRTY) && SampleStart && !PushCoef;

    fir_coef_bank shadow (
        .clk         (clk),
        .rst_n       (Reset),
        .wr_en_i     (wr_ok),
        .wr_addr_i   (tap_idx),
        .wr_data_i   (wr_coef),
        .load_en_i   (1'b0),
        .load_data_i ('0),
        .data_o      (shadow_bank)
    );

    fir_coef_bank active (
        .clk         (clk),
        .rst_n       (Reset),
        .wr_en_i     (1'b0),
        .wr_addr_i   ('0),
        .wr_data_i   ('0),
        .load_en_i   (swap),
        .load_data_i (shadow_bank),
        .data_o      (active_bank)
    );

    assign active_next = swap ? shadow_bank : active_bank;

    always_comb begin
        mask_d = mask_q;
        if (wr_ok) begin
            mask_d[tap_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (&mask_d) state_d = ST_DIRTY;
            ST_DIRTY: if (swap)    state_d = ST_CLEAN;
            ST_CLEAN: if (wr_ok)   state_d = ST_DIRTY;
            default:               state_d = ST_EMPTY;
        endcase
    end

    assign valid_d = valid_q || swap;
    assign err_d   = PushCoef && !addr_legal;

    // Group outputs look at the post-edge bank so a swap is visible on the same edge.
    always_comb begin
        grp_i_d = '0;
        grp_q_d = '0;
        grp_tap = '0;
        if (valid_d && (int'(GroupSel) < NUM_GROUPS)) begin
            for (int k = 0; k < GROUP_SIZE; k++) begin
                grp_tap = TAP_IDX_W'(GROUP_SIZE * int'(GroupSel) + k);
                grp_i_d[k*COEF_W +: COEF_W] = active_next[grp_tap].i;
                grp_q_d[k*COEF_W +: COEF_W] = active_next[grp_tap].q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state logic lives in always_comb.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= ST_EMPTY;
            mask_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            grp_i_q <= '0;
            grp_q_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            grp_i_q <= grp_i_d;
            grp_q_q <= grp_q_d;
        end
    end

    assign CoefGrpI    = grp_i_q;
    assign CoefGrpQ    = grp_q_q;
    assign CoefValid   = valid_q;
    assign SwapPending = (state_q == ST_DIRTY);
    assign CoefErr     = err_q;
endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Scoreboard bench for fir_coef_bank_ctrl: a bank-level reference model predicts
// every cycle's outputs, and a monitor compares them on the falling edge.
`timescale 1ns/1ps
module tb_fir_coef_bank_ctrl;
    import fir_pkg::*;

    logic              clk = 1'b0;
    logic              Reset;
    logic              PushCoef;
    logic [ADDR_W-1:0] CoefAddr;
    logic [COEF_W-1:0] CoefI;
    logic [COEF_W-1:0] CoefQ;
    logic              SampleStart;
    logic [1:0]        GroupSel;
    logic [GRP_W-1:0]  CoefGrpI;
    logic [GRP_W-1:0]  CoefGrpQ;
    logic              CoefValid;
    logic              SwapPending;
    logic              CoefErr;

    always #5 clk = ~clk;

    fir_coef_bank_ctrl dut (
        .clk         (clk),
        .Reset       (Reset),
        .PushCoef    (PushCoef),
        .CoefAddr    (CoefAddr),
        .CoefI       (CoefI),
        .CoefQ       (CoefQ),
        .SampleStart (SampleStart),
        .GroupSel    (GroupSel),
        .CoefGrpI    (CoefGrpI),
        .CoefGrpQ    (CoefGrpQ),
        .CoefValid   (CoefValid),
        .SwapPending (SwapPending),
        .CoefErr     (CoefErr)
    );

    typedef struct {
        logic [GRP_W-1:0] gi;
        logic [GRP_W-1:0] gq;
        logic             valid;
        logic             pend;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: two coefficient arrays, a set of loaded taps and three flags.
    logic [COEF_W-1:0] m_sh_i [NUM_UNIQUE_TAPS];
    logic [COEF_W-1:0] m_sh_q [NUM_UNIQUE_TAPS];
    logic [COEF_W-1:0] m_ac_i [NUM_UNIQUE_TAPS];
    logic [COEF_W-1:0] m_ac_q [NUM_UNIQUE_TAPS];
    bit                m_loaded [NUM_UNIQUE_TAPS];
    bit                m_valid;
    bit                m_pend;
    bit                m_err;

    task automatic check(input string name, input logic [GRP_W-1:0] act, input logic [GRP_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic push, input logic [ADDR_W-1:0] addr,
                              input logic [COEF_W-1:0] ci, input logic [COEF_W-1:0] cq,
                              input logic ss, input logic [1:0] gs);
        exp_t e;
        bit   do_swap;
        int   n_loaded;
        if (!rst) begin
            for (int t = 0; t < NUM_UNIQUE_TAPS; t++) begin
                m_sh_i[t] = '0; m_sh_q[t] = '0; m_ac_i[t] = '0; m_ac_q[t] = '0;
                m_loaded[t] = 1'b0;
            end
            m_valid = 1'b0; m_pend = 1'b0; m_err = 1'b0;
        end else begin
            do_swap = m_pend && ss && !push;
            m_err   = push && (int'(addr) >= NUM_UNIQUE_TAPS);
            if (push && int'(addr) < NUM_UNIQUE_TAPS) begin
                m_sh_i[addr]   = ci;
                m_sh_q[addr]   = cq;
                m_loaded[addr] = 1'b1;
                n_loaded = 0;
                for (int t = 0; t < NUM_UNIQUE_TAPS; t++) n_loaded += int'(m_loaded[t]);
                if (n_loaded == NUM_UNIQUE_TAPS) m_pend = 1'b1;
            end
            if (do_swap) begin
                m_ac_i  = m_sh_i;
                m_ac_q  = m_sh_q;
                m_valid = 1'b1;
                m_pend  = 1'b0;
            end
        end
        e.gi = '0;
        e.gq = '0;
        if (m_valid && int'(gs) < NUM_GROUPS) begin
            for (int k = 0; k < GROUP_SIZE; k++) begin
                e.gi[k*COEF_W +: COEF_W] = m_ac_i[GROUP_SIZE*int'(gs) + k];
                e.gq[k*COEF_W +: COEF_W] = m_ac_q[GROUP_SIZE*int'(gs) + k];
            end
        end
        e.valid = m_valid;
        e.pend  = m_pend;
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    // Called right after a falling edge; applies one cycle of stimulus.
    task automatic step(input logic rst, input logic push, input logic [ADDR_W-1:0] addr,
                        input logic [COEF_W-1:0] ci, input logic [COEF_W-1:0] cq,
                        input logic ss, input logic [1:0] gs);
        Reset = rst; PushCoef = push; CoefAddr = addr; CoefI = ci; CoefQ = cq;
        SampleStart = ss; GroupSel = gs;
        @(posedge clk);
        model_step(rst, push, addr, ci, cq, ss, gs);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [1:0] gs);
        for (int c = 0; c < n; c++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, gs);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("CoefGrpI", CoefGrpI, e.gi);
                check("CoefGrpQ", CoefGrpQ, e.gq);
                check("CoefValid", GRP_W'(CoefValid), GRP_W'(e.valid));
                check("SwapPending", GRP_W'(SwapPending), GRP_W'(e.pend));
                check("CoefErr", GRP_W'(CoefErr), GRP_W'(e.err));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        Reset = 1'b0; PushCoef = 1'b0; CoefAddr = '0; CoefI = '0; CoefQ = '0;
        SampleStart = 1'b0; GroupSel = '0;
        @(negedge clk);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 5'd2, 27'h1, 27'h1, 1'b1, 2'd0);

        // Full load with I=addr+1, Q=-(addr+1), then one sample boundary.
        for (int a = 0; a < NUM_UNIQUE_TAPS; a++)
            step(1'b1, 1'b1, ADDR_W'(a), COEF_W'(a + 1), COEF_W'(-(a + 1)), 1'b0, 2'd1);
        idle(2, 2'd1);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 2'd1);
        idle(2, 2'd1);
        idle(2, 2'd3);
        idle(1, 2'd2);

        // Write coinciding with SampleStart defers the swap.
        step(1'b1, 1'b1, 5'd7, 27'h100000, COEF_W'(-8), 1'b1, 2'd1);
        idle(2, 2'd1);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 2'd1);
        idle(2, 2'd1);

        // Illegal addresses.
        step(1'b1, 1'b1, 5'd20, 27'h7ABCDEF, 27'h1234567, 1'b0, 2'd0);
        idle(1, 2'd0);
        step(1'b1, 1'b1, 5'd15, 27'h5555555, 27'h2AAAAAA, 1'b1, 2'd0);
        step(1'b1, 1'b1, 5'd31, 27'h0000001, 27'h0000002, 1'b0, 2'd1);
        idle(2, 2'd1);

        // Reset while a swap is pending.
        step(1'b1, 1'b1, 5'd3, 27'h0ABCDEF, 27'h0FEDCBA, 1'b0, 2'd0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 2'd0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 2'd0);
        idle(2, 2'd0);

        // Fourteen taps only: no swap may happen.
        for (int a = 0; a < NUM_UNIQUE_TAPS; a++)
            if (a != 9) step(1'b1, 1'b1, ADDR_W'(a), COEF_W'(a + 100), COEF_W'(a + 200), 1'b0, 2'd0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 2'd0);
        idle(2, 2'd1);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 5),
                 ADDR_W'($urandom_range(0, 17)),
                 COEF_W'($urandom),
                 COEF_W'($urandom),
                 ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)));
        end
        idle(2, 2'd0);

        #1;
        check("scoreboard_drained", GRP_W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
